spu_wb_arbiter: RTL and testbench
=================================

Name: spu_wb_arbiter

Overview:
Writeback arbiter between the SPU execution pipes and the 128x128 register file's two write ports.
- Accepts up to NUM_REQ result requests per cycle and grants at most two, round-robin.
- Never grants two results to the same destination register in the same cycle.
- Drives registered write-port controls (en/addr/data x2) straight into the register file.

Parameters:
NUM_REQ, 4, number of requesting execution pipes (2..8)
ADDR_W, 7, register address width (128 registers)
DATA_W, 128, register data width
CNT_W, 16, width of saturating conflict counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (state cleared on posedge clk while rst==0)
wb_stall  input  1  1 = grant nothing this cycle
req_valid  input  NUM_REQ  per-pipe result valid; bit i = pipe i
req_addr  input  NUM_REQ*ADDR_W  dest addresses; pipe i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  result data; pipe i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  combinational grant; transfer when valid&ready
reg_write_en_1  output  1  registered write enable, port 1
reg_write_addr_1  output  ADDR_W  registered address, port 1
reg_write_data_1  output  DATA_W  registered data, port 1
reg_write_en_2  output  1  registered write enable, port 2
reg_write_addr_2  output  ADDR_W  registered address, port 2
reg_write_data_2  output  DATA_W  registered data, port 2
conflict_cnt  output  CNT_W  saturating count of same-address deferrals

Behaviour:
Reset (rst==0 at posedge):
- en_1/en_2 = 0; addr_1/2 = 0; data_1/2 = 0; rr_ptr = 0; conflict_cnt = 0.
- req_ready is forced to 0 while rst==0.

Handshake:
- Requester holds valid/addr/data stable until accepted.
- req_ready[i] is a pure function of the current inputs and rr_ptr; no combinational dependence on the register file.

Grant selection, per cycle, when wb_stall==0 and rst==1:
- Scan order: rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
- Winner A (port 1): the first valid requester.
- Winner B (port 2): the next valid requester after A in scan order whose addr != addr(A).
- Any valid requester scanned between A and B (or after A when no B is found) whose addr == addr(A) is deferred: it gets no ready and counts as one conflict.
- conflict_cnt += number of deferred requesters; saturates at all-ones, never wraps.
- Requesters beyond B in scan order are not granted; they are not conflicts.
- req_ready = onehot(A) | onehot(B).

Pointer update:
- rr_ptr_next = (index of last winner in scan order + 1) mod NUM_REQ, i.e. after B if B exists, else after A.
- No grant: rr_ptr unchanged.

Output registers (1-cycle latency):
- At the posedge ending grant cycle T, port 1 loads A's addr/data with en_1=1, and port 2 loads B's addr/data with en_2=1.
- A missing winner gives en=0; its addr/data hold their previous values.
- The register file therefore commits at the end of cycle T+1.

Stall:
- wb_stall==1: req_ready = 0, next en_1 = en_2 = 0, rr_ptr and conflict_cnt held.

Boundary conditions:
- Only one valid requester: goes to port 1; port 2 idle.
- All valid requesters target the same address: one grant per cycle, rotating among them.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles, provided the stall is low.
- Reset mid-operation: a registered write in flight is dropped (en cleared). Requesters must re-present.

Decomposition:
- Shared package spu_pkg: REG_ADDR_W=7, REG_DATA_W=128, NUM_REGS=128, SPU_NUM_WB_REQ=4. Used by the register file and this block.
- One sub-module, spu_rr_pick: rotating-priority find-first.
  - Inputs: mask, start pointer. Outputs: onehot, index, found.
  - Instantiated twice: A = pick(req_valid, rr_ptr); B = pick(req_valid & ~onehot(A) & ~same_addr_as_A, A+1).
  - The deferred set is computed outside the picker from the scan-order range between A and B.

Test Plan:
- Reset: rst=0 for 2 cycles with all req_valid=1 -> req_ready=0000, en_1=en_2=0, conflict_cnt=0; first cycle after release grants pipes 0 and 1.
- Two distinct: rr_ptr=0, valid=0101, addr0=5 data0=0xAA.., addr2=9 data2=0xBB.. -> ready=0101; next cycle en_1=1 addr_1=5, en_2=1 addr_2=9; rr_ptr becomes 3.
- Same-address conflict: rr_ptr=0, valid=0111, addrs 12,12,30 -> ready=0101 (pipes 0,2); conflict_cnt 0->1; pipe 1 granted to port 1 on the following cycle (rr_ptr=3 wraps to pipe 1).
- Fairness: all 4 valid with distinct addrs held 4 cycles -> grants {0,1},{2,3},{0,1},{2,3}; every pipe served within 2 cycles.
- Stall: wb_stall=1 with valid=1111 -> ready=0000, next en=0, rr_ptr unchanged; deassert -> grant resumes from the same rr_ptr.
- Saturation: preload traffic producing 3 deferrals per cycle with conflict_cnt near 0xFFFF -> sticks at 0xFFFF, does not wrap.

Source files
------------

// File: rtl/spu_pkg.sv
// -----------------------------------------------------------------------------
// spu_pkg
// Shared SPU constants used by the register file and the writeback arbiter.
// No ports. Provides:
//   REG_ADDR_W      register address width
//   REG_DATA_W      register data width
//   NUM_REGS        number of architectural registers
//   SPU_NUM_WB_REQ  number of execution pipes competing for writeback
//   wrap_inc()      modulo-n increment used for rotating pointers
// -----------------------------------------------------------------------------
package spu_pkg;

   localparam int REG_ADDR_W     = 7;
   localparam int REG_DATA_W     = 128;
   localparam int NUM_REGS       = 128;
   localparam int SPU_NUM_WB_REQ = 4;

   // Rotating-pointer step: returns (idx + 1) mod n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/spu_rr_pick.sv
// -----------------------------------------------------------------------------
// spu_rr_pick
// Rotating-priority find-first: scans mask_i starting at start_i and wrapping
// around, returning the first set position.
// Ports:
//   mask_i    candidate bits, one per requester
//   start_i   index the scan begins at (highest priority)
//   onehot_o  one-hot of the selected position (all zero when none)
//   idx_o     binary index of the selected position (0 when none)
//   found_o   1 when any bit of mask_i is set
// -----------------------------------------------------------------------------
module spu_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     mask_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   // Walk the N positions in priority order; the first hit wins and later
   // hits are ignored once found_o is set.
   always_comb begin
      logic [IDX_W-1:0] pos;
      onehot_o = '0;
      idx_o    = '0;
      found_o  = 1'b0;
      pos      = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'((int'(start_i) + k) % N);
         if (!found_o && mask_i[pos]) begin
            found_o       = 1'b1;
            idx_o         = pos;
            onehot_o[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// spu_wb_arbiter
// Writeback arbiter between the SPU execution pipes and the two write ports
// of the register file. Grants up to two results per cycle, round-robin,
// never two to the same destination register, and registers the write-port
// controls so they can drive the register file directly.
// Ports:
//   clk, rst           clock and synchronous active-low reset
//   wb_stall           1 = grant nothing this cycle
//   req_valid/addr/data  per-pipe result requests (pipe i in slice i)
//   req_ready          combinational grant, transfer on valid & ready
//   reg_write_*_1/_2   registered enable/address/data for write ports 1 and 2
//   conflict_cnt       saturating count of same-address deferrals
// -----------------------------------------------------------------------------
module spu_wb_arbiter
   import spu_pkg::*;
#(
   parameter int NUM_REQ = SPU_NUM_WB_REQ,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      reg_write_en_1,
   output logic [ADDR_W-1:0]         reg_write_addr_1,
   output logic [DATA_W-1:0]         reg_write_data_1,
   output logic                      reg_write_en_2,
   output logic [ADDR_W-1:0]         reg_write_addr_2,
   output logic [DATA_W-1:0]         reg_write_data_2,
   output logic [CNT_W-1:0]          conflict_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               en_1_q, en_1_d, en_2_q, en_2_d;
   logic [ADDR_W-1:0]  addr_1_q, addr_2_q;
   logic [DATA_W-1:0]  data_1_q, data_2_q;

   logic               grant_en;
   logic [NUM_REQ-1:0] a_onehot, b_onehot, same_addr, b_mask;
   logic [IDX_W-1:0]   a_idx, b_idx, b_start;
   logic               a_found, b_found;
   logic [ADDR_W-1:0]  a_addr, b_addr;
   logic [DATA_W-1:0]  a_data, b_data;
   logic [IDX_W:0]     defer_cnt;
   logic [CNT_W:0]     cnt_sum;

   assign grant_en = rst && !wb_stall;

   spu_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_a (
      .mask_i   (req_valid),
      .start_i  (rr_ptr_q),
      .onehot_o (a_onehot),
      .idx_o    (a_idx),
      .found_o  (a_found)
   );

   assign a_addr = req_addr[a_idx*ADDR_W +: ADDR_W];
   assign a_data = req_data[a_idx*DATA_W +: DATA_W];

   // Valid requesters aiming at the same register as A (A itself included);
   // these are excluded from the port-2 search.
   always_comb begin
      same_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         same_addr[i] = req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == a_addr);
      end
   end

   assign b_mask  = req_valid & ~a_onehot & ~same_addr;
   assign b_start = IDX_W'(wrap_inc(int'(a_idx), NUM_REQ));

   spu_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_b (
      .mask_i   (b_mask),
      .start_i  (b_start),
      .onehot_o (b_onehot),
      .idx_o    (b_idx),
      .found_o  (b_found)
   );

   assign b_addr = req_addr[b_idx*ADDR_W +: ADDR_W];
   assign b_data = req_data[b_idx*DATA_W +: DATA_W];

   // Deferred requesters share A's address and sit after A but before B in
   // scan order (or anywhere after A when there is no B). Distance is taken
   // relative to A; everything between rr_ptr and A is invalid, so scanning
   // from A onward covers the same set as scanning from rr_ptr.
   always_comb begin
      int dist_i, dist_b;
      defer_cnt = '0;
      dist_i    = 0;
      dist_b    = b_found ? ((int'(b_idx) + NUM_REQ - int'(a_idx)) % NUM_REQ) : NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_i = (i + NUM_REQ - int'(a_idx)) % NUM_REQ;
         if (same_addr[i] && dist_i != 0 && dist_i < dist_b) begin
            defer_cnt = defer_cnt + 1'b1;
         end
      end
   end

   // The carry out of the widened sum marks overflow; clamp instead of wrap.
   assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(defer_cnt);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      en_1_d   = grant_en && a_found;
      en_2_d   = grant_en && b_found;
      if (grant_en && a_found) begin
         rr_ptr_d = b_found ? IDX_W'(wrap_inc(int'(b_idx), NUM_REQ))
                            : IDX_W'(wrap_inc(int'(a_idx), NUM_REQ));
         cnt_d    = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end

   assign req_ready = grant_en ? (a_onehot | b_onehot) : '0;

   // Write-port registers: address/data only move when a winner exists so a
   // dropped enable leaves the previous values visible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         en_1_q   <= 1'b0;
         en_2_q   <= 1'b0;
         addr_1_q <= '0;
         addr_2_q <= '0;
         data_1_q <= '0;
         data_2_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         en_1_q   <= en_1_d;
         en_2_q   <= en_2_d;
         if (en_1_d) begin
            addr_1_q <= a_addr;
            data_1_q <= a_data;
         end
         if (en_2_d) begin
            addr_2_q <= b_addr;
            data_2_q <= b_data;
         end
      end
   end

   assign reg_write_en_1   = en_1_q;
   assign reg_write_addr_1 = addr_1_q;
   assign reg_write_data_1 = data_1_q;
   assign reg_write_en_2   = en_2_q;
   assign reg_write_addr_2 = addr_2_q;
   assign reg_write_data_2 = data_2_q;
   assign conflict_cnt     = cnt_q;

endmodule

// File: tb/tb_spu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spu_wb_arbiter
// Directed, table-driven bench for spu_wb_arbiter with the default sizing
// (4 pipes, 7-bit addresses, 128-bit data, 16-bit conflict counter).
// -----------------------------------------------------------------------------
module tb_spu_wb_arbiter;

   localparam int N  = 4;
   localparam int AW = 7;
   localparam int DW = 128;
   localparam int CW = 16;
   localparam int NV = 23;

   logic            clk;
   logic            rst;
   logic            wb_stall;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            reg_write_en_1;
   logic [AW-1:0]   reg_write_addr_1;
   logic [DW-1:0]   reg_write_data_1;
   logic            reg_write_en_2;
   logic [AW-1:0]   reg_write_addr_2;
   logic [DW-1:0]   reg_write_data_2;
   logic [CW-1:0]   conflict_cnt;

   typedef struct {
      logic            rst;
      logic            stall;
      logic [N-1:0]    valid;
      logic [N*AW-1:0] addrs;
      logic [N-1:0]    ready;
      logic            en1;
      int              p1;
      logic            en2;
      int              p2;
      int              cnt;
   } vec_t;

   vec_t          vecs [NV];
   int            nChecks;
   int            nFail;
   logic [AW-1:0] heldAddr1, heldAddr2;
   logic [DW-1:0] heldData1, heldData2;

   spu_wb_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .wb_stall         (wb_stall),
      .req_valid        (req_valid),
      .req_addr         (req_addr),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .reg_write_en_1   (reg_write_en_1),
      .reg_write_addr_1 (reg_write_addr_1),
      .reg_write_data_1 (reg_write_data_1),
      .reg_write_en_2   (reg_write_en_2),
      .reg_write_addr_2 (reg_write_addr_2),
      .reg_write_data_2 (reg_write_data_2),
      .conflict_cnt     (conflict_cnt)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each pipe's data encodes its pipe number and destination so a swapped
   // port or wrong slice shows up in the data compare.
   function automatic logic [DW-1:0] mkData(input int p, input logic [AW-1:0] a);
      return {96'hDEADBEEF_01234567_89ABCDEF, 8'(p), 1'b0, a, 16'hA55A};
   endfunction

   function automatic vec_t mkVec(input logic r, input logic s, input logic [N-1:0] v,
                                  input int a0, input int a1, input int a2, input int a3,
                                  input logic [N-1:0] rdy, input logic e1, input int q1,
                                  input logic e2, input int q2, input int c);
      vec_t t;
      t.rst   = r;
      t.stall = s;
      t.valid = v;
      t.addrs = {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
      t.ready = rdy;
      t.en1   = e1;
      t.p1    = q1;
      t.en2   = e2;
      t.p2    = q2;
      t.cnt   = c;
      return t;
   endfunction

   function automatic logic [AW-1:0] addrOf(input vec_t v, input int p);
      return v.addrs[p*AW +: AW];
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      wb_stall  = v.stall;
      req_valid = v.valid;
      req_addr  = v.addrs;
      for (int i = 0; i < N; i++) begin
         req_data[i*DW +: DW] = mkData(i, v.addrs[i*AW +: AW]);
      end
   endtask

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle: drive, check the combinational grant mid-cycle, clock, then
   // check the registered ports against the bench's own held-value model.
   task automatic runVector(input vec_t v, input string tag);
      applyStimulus(v);
      #2;
      checkOutput({tag, " ready"}, DW'(req_ready), DW'(v.ready));
      @(posedge clk);
      #1;
      if (!v.rst) begin
         heldAddr1 = '0; heldData1 = '0;
         heldAddr2 = '0; heldData2 = '0;
      end else begin
         if (v.en1) begin
            heldAddr1 = addrOf(v, v.p1);
            heldData1 = mkData(v.p1, heldAddr1);
         end
         if (v.en2) begin
            heldAddr2 = addrOf(v, v.p2);
            heldData2 = mkData(v.p2, heldAddr2);
         end
      end
      checkOutput({tag, " en1"},   DW'(reg_write_en_1),   DW'(v.en1));
      checkOutput({tag, " addr1"}, DW'(reg_write_addr_1), DW'(heldAddr1));
      checkOutput({tag, " data1"}, reg_write_data_1,      heldData1);
      checkOutput({tag, " en2"},   DW'(reg_write_en_2),   DW'(v.en2));
      checkOutput({tag, " addr2"}, DW'(reg_write_addr_2), DW'(heldAddr2));
      checkOutput({tag, " data2"}, reg_write_data_2,      heldData2);
      checkOutput({tag, " cnt"},   DW'(conflict_cnt),     DW'(v.cnt));
   endtask

   initial begin
      nChecks   = 0;
      nFail     = 0;
      heldAddr1 = '0; heldData1 = '0;
      heldAddr2 = '0; heldData2 = '0;
      rst       = 1'b0;
      wb_stall  = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;

      // Fields: rst stall valid | addr0..3 | ready en1 p1 en2 p2 cnt
      // Reset held two cycles with everyone requesting, then release.
      vecs[0]  = mkVec(0, 0, 4'hF,  1,  2,  3,  4, 4'h0, 0, 0, 0, 0,  0);
      vecs[1]  = mkVec(0, 0, 4'hF,  1,  2,  3,  4, 4'h0, 0, 0, 0, 0,  0);
      vecs[2]  = mkVec(1, 0, 4'hF,  1,  2,  3,  4, 4'h3, 1, 0, 1, 1,  0);
      vecs[3]  = mkVec(1, 0, 4'hC,  1,  2,  3,  4, 4'hC, 1, 2, 1, 3,  0);
      // Two distinct requesters from rr_ptr=0, then single requester.
      vecs[4]  = mkVec(1, 0, 4'h5,  5,  7,  9, 11, 4'h5, 1, 0, 1, 2,  0);
      vecs[5]  = mkVec(1, 0, 4'h8,  5,  7,  9, 11, 4'h8, 1, 3, 0, 0,  0);
      // Same-address conflict, deferred pipe wins next cycle via wrap.
      vecs[6]  = mkVec(1, 0, 4'h7, 12, 12, 30, 40, 4'h5, 1, 0, 1, 2,  1);
      vecs[7]  = mkVec(1, 0, 4'h2, 12, 12, 30, 40, 4'h2, 1, 1, 0, 0,  1);
      // Stall holds pointer, resume from it.
      vecs[8]  = mkVec(1, 1, 4'hF, 20, 21, 22, 23, 4'h0, 0, 0, 0, 0,  1);
      vecs[9]  = mkVec(1, 0, 4'hF, 20, 21, 22, 23, 4'hC, 1, 2, 1, 3,  1);
      // Fairness with all four distinct.
      vecs[10] = mkVec(1, 0, 4'hF, 20, 21, 22, 23, 4'h3, 1, 0, 1, 1,  1);
      vecs[11] = mkVec(1, 0, 4'hF, 20, 21, 22, 23, 4'hC, 1, 2, 1, 3,  1);
      vecs[12] = mkVec(1, 0, 4'hF, 20, 21, 22, 23, 4'h3, 1, 0, 1, 1,  1);
      vecs[13] = mkVec(1, 0, 4'hF, 20, 21, 22, 23, 4'hC, 1, 2, 1, 3,  1);
      // All same address: one grant per cycle rotating, 3 deferrals each.
      vecs[14] = mkVec(1, 0, 4'hF, 50, 50, 50, 50, 4'h1, 1, 0, 0, 0,  4);
      vecs[15] = mkVec(1, 0, 4'hF, 50, 50, 50, 50, 4'h2, 1, 1, 0, 0,  7);
      vecs[16] = mkVec(1, 0, 4'hF, 50, 50, 50, 50, 4'h4, 1, 2, 0, 0, 10);
      vecs[17] = mkVec(1, 0, 4'hF, 50, 50, 50, 50, 4'h8, 1, 3, 0, 0, 13);
      // Same-address pipe beyond B is not a conflict; wrapped deferrals are.
      vecs[18] = mkVec(1, 0, 4'hF,  5,  6,  5,  7, 4'h3, 1, 0, 1, 1, 13);
      vecs[19] = mkVec(1, 0, 4'hF,  8,  9,  8,  8, 4'h6, 1, 2, 1, 1, 15);
      // Single requester, then idle, then resume from pointer 1.
      vecs[20] = mkVec(1, 0, 4'h1, 77,  9,  8,  8, 4'h1, 1, 0, 0, 0, 15);
      vecs[21] = mkVec(1, 0, 4'h0, 77,  9,  8,  8, 4'h0, 0, 0, 0, 0, 15);
      vecs[22] = mkVec(1, 0, 4'hF,  1,  2,  3,  4, 4'h6, 1, 1, 1, 2, 15);

      for (int v = 0; v < NV; v++) begin
         runVector(vecs[v], $sformatf("v%0d", v));
      end

      // Reset while a write is in flight: the enables must drop.
      runVector(mkVec(1, 0, 4'h3, 60, 61, 0, 0, 4'h3, 1, 0, 1, 1, 15), "inflight");
      runVector(mkVec(0, 0, 4'h3, 60, 61, 0, 0, 4'h0, 0, 0, 0, 0,  0), "midreset");

      // Saturation: one cycle with a single deferral, then 3 per cycle until
      // the counter sits at 0xFFFD; the next +3 must clamp to 0xFFFF.
      runVector(mkVec(1, 0, 4'h3, 70, 70, 0, 0, 4'h1, 1, 0, 0, 0, 1), "sat0");
      applyStimulus(mkVec(1, 0, 4'hF, 70, 70, 70, 70, 4'h0, 0, 0, 0, 0, 0));
      #2;
      checkOutput("sat ready", DW'(req_ready), DW'(4'h2));
      for (int c = 0; c < 21844; c++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("sat pre", DW'(conflict_cnt), DW'(16'hFFFD));
      checkOutput("sat en1", DW'(reg_write_en_1), DW'(1'b1));
      checkOutput("sat addr1", DW'(reg_write_addr_1), DW'(7'd70));
      @(posedge clk);
      #1;
      checkOutput("sat clamp", DW'(conflict_cnt), DW'(16'hFFFF));
      @(posedge clk);
      #1;
      checkOutput("sat hold", DW'(conflict_cnt), DW'(16'hFFFF));

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
